// File: rtl/apb_slave_mem_responder_pkg.sv
// Shared types and globals for the APB memory responder slice.
//   resp_state_e  : responder FSM states (IDLE, ACCESS)
//   slave_error_e : latched completion status (NO_ERROR, ERROR)
//   tx_type_e     : latched transfer direction (WRITE, READ)
//   APB_ADDRESS_WIDTH / APB_DATA_WIDTH : default bus widths
package apb_slave_mem_responder_pkg;

  localparam int unsigned APB_ADDRESS_WIDTH = 32;
  localparam int unsigned APB_DATA_WIDTH    = 32;

  typedef enum logic {
    IDLE,
    ACCESS
  } resp_state_e;

  typedef enum logic {
    NO_ERROR,
    ERROR
  } slave_error_e;

  typedef enum logic {
    WRITE,
    READ
  } tx_type_e;

endpackage

// File: rtl/apb_slave_mem_responder_mem_array.sv
// MEM_WORDS x 32-bit register array.
//   clk_i, rst_i : clock, asynchronous active-high reset (clears all words)
//   we_i         : write enable, qualified per byte by wstrb_i
//   waddr_i      : write word index; wdata_i / wstrb_i : data and byte strobes
//   raddr_i      : combinational read word index; rdata_o : read data
module apb_slave_mem_array #(
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem_responder.sv
// APB completer backed by a small word memory.
//   pclk, preset        : clock, asynchronous active-high reset
//   psel, penable       : APB select / access-phase strobe
//   pwrite, paddr       : direction, byte address
//   pwdata, pstrb       : write data, byte strobes (ignored on reads)
//   pprot               : protection; bit1 = non-secure
//   cfg_wait_states     : wait states for the next transfer, sampled in setup
//   pready, pslverr     : registered completion and error response
//   prdata              : registered read data (0 on error and on writes)
module apb_slave_mem_responder
  import apb_slave_mem_responder_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = APB_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = APB_DATA_WIDTH,
  parameter int unsigned MEM_WORDS     = 64,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter bit          SECURE_UPPER  = 1'b1
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [ADDRESS_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]    pwdata,
  input  logic [DATA_WIDTH/8-1:0]  pstrb,
  input  logic [2:0]               pprot,
  input  logic [3:0]               cfg_wait_states,
  output logic                     pready,
  output logic                     pslverr,
  output logic [DATA_WIDTH-1:0]    prdata
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDRESS_WIDTH:0]   SPAN = (ADDRESS_WIDTH+1)'(MEM_WORDS * 4);
  localparam logic [ADDRESS_WIDTH-1:0] BASE = BASE_ADDR[ADDRESS_WIDTH-1:0];

  resp_state_e               state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  tx_type_e                  tx_q, tx_d;
  slave_error_e              err_q, err_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   strb_q, strb_d;
  logic [DATA_WIDTH-1:0]     rhold_q, rhold_d;
  logic                      pready_q, pready_d;
  logic                      pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]     prdata_q, prdata_d;

  logic [ADDRESS_WIDTH-1:0]  offset;
  logic [IDX_W-1:0]          setup_idx;
  logic                      setup_err;
  logic [31:0]               mem_rdata;
  logic                      mem_we;
  logic                      unused_prot;

  // Decode uses a one-bit-wider compare so BASE + span never wraps.
  assign offset    = paddr - BASE;
  assign setup_idx = offset[IDX_W+1:2];
  assign setup_err = (paddr < BASE) || ({1'b0, offset} >= SPAN) ||
                     (paddr[1:0] != 2'b00) ||
                     (SECURE_UPPER && pprot[1] && setup_idx[IDX_W-1]);
  assign unused_prot = pprot[0] ^ pprot[2];

  apb_slave_mem_array #(
    .MEM_WORDS (MEM_WORDS)
  ) u_mem (
    .clk_i   (pclk),
    .rst_i   (preset),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .wstrb_i (strb_q),
    .raddr_i (setup_idx),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rhold_d   = rhold_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    mem_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = cfg_wait_states;
          idx_d   = setup_idx;
          tx_d    = pwrite ? WRITE : READ;
          err_d   = setup_err ? ERROR : NO_ERROR;
          wdata_d = pwdata;
          strb_d  = pstrb;
          rhold_d = setup_err ? '0 : mem_rdata;
          // Outputs are registered, so zero-wait completion is decided here.
          if (cfg_wait_states == 4'd0) begin
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            prdata_d  = (setup_err || pwrite) ? '0 : mem_rdata;
          end
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (pready_q) begin
          if (penable) begin
            state_d = IDLE;
            mem_we  = (tx_q == WRITE) && (err_q == NO_ERROR);
          end else begin
            pready_d  = 1'b1;
            pslverr_d = pslverr_q;
            prdata_d  = prdata_q;
          end
        end else begin
          // pready_q low in ACCESS implies cnt_q > 0.
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = (err_q == ERROR);
            prdata_d  = (tx_q == READ) ? rhold_q : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      tx_q      <= READ;
      err_q     <= NO_ERROR;
      wdata_q   <= '0;
      strb_q    <= '0;
      rhold_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      rhold_q   <= rhold_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem_responder.sv
module tb_apb_slave_mem_responder;

  logic        pclk;
  logic        preset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [3:0]  cfg_wait_states;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference memory image: 64 words at base 0, upper 32 words secure-only.
  logic [31:0] mem_m [64];

  apb_slave_mem_responder #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .MEM_WORDS     (64),
    .BASE_ADDR     (32'h0000_0000),
    .SECURE_UPPER  (1'b1)
  ) dut (
    .pclk            (pclk),
    .preset          (preset),
    .psel            (psel),
    .penable         (penable),
    .pwrite          (pwrite),
    .paddr           (paddr),
    .pwdata          (pwdata),
    .pstrb           (pstrb),
    .pprot           (pprot),
    .cfg_wait_states (cfg_wait_states),
    .pready          (pready),
    .pslverr         (pslverr),
    .prdata          (prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a, input logic [2:0] p);
    return (a >= 32'h100) || (a[1:0] != 2'b00) ||
           (p[1] && (a >= 32'h80) && (a < 32'h100));
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) mem_m[a[7:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot, input int w);
    int          lat;
    logic        e_err;
    logic [31:0] e_rd;
    @(negedge pclk);
    chk("idle_pready", {31'b0, pready}, 32'd0);
    e_err = model_err(addr, prot);
    e_rd  = e_err ? 32'h0 : mem_m[addr[7:2]];
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    pstrb = strb; pprot = prot; cfg_wait_states = w[3:0];
    @(posedge pclk);
    @(negedge pclk);
    penable = 1'b1;
    cfg_wait_states = 4'($urandom_range(15, 0));
    lat = 1;
    while (pready !== 1'b1 && lat <= 40) begin
      @(negedge pclk);
      lat++;
    end
    chk("latency", lat, w + 1);
    chk("pslverr", {31'b0, pslverr}, {31'b0, e_err});
    if (!wr) chk("prdata", prdata, e_rd);
    @(posedge pclk);
    #1;
    if (wr && !e_err) model_write(addr, data, strb);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [2:0] prot, input int w);
    apb_xfer(1'b0, addr, $urandom, 4'($urandom), prot, w);
  endtask

  task automatic idle(input int n);
    @(negedge pclk);
    chk("idle_pready", {31'b0, pready}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    repeat (n) @(negedge pclk);
  endtask

  // Starts a write with a long wait, then drops psel after k access cycles.
  task automatic abort_xfer(input logic [31:0] addr, input logic [31:0] data, input int k);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    pstrb = 4'hF; pprot = 3'b000; cfg_wait_states = 4'd5;
    @(posedge pclk);
    @(negedge pclk);
    penable = 1'b1;
    for (int i = 0; i < k; i++) begin
      @(negedge pclk);
      chk("abort_wait_pready", {31'b0, pready}, 32'd0);
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    chk("abort_pready", {31'b0, pready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;
    for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0; pprot = '0; cfg_wait_states = '0;
    repeat (2) @(negedge pclk);
    chk("rst_pready", {31'b0, pready}, 32'd0);
    chk("rst_pslverr", {31'b0, pslverr}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    preset = 1'b0;

    // Basic write/read, zero wait
    apb_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000, 0);
    rd(32'h10, 3'b000, 0);
    chk("deadbeef_model", mem_m[4], 32'hDEAD_BEEF);

    // Partial strobes, back-to-back
    apb_xfer(1'b1, 32'h20, 32'h1122_3344, 4'b0101, 3'b000, 0);
    rd(32'h20, 3'b000, 0);
    chk("strobe_model", mem_m[8], 32'h0022_0044);

    // pstrb=0 writes nothing, no error
    apb_xfer(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 3'b000, 1);
    rd(32'h20, 3'b000, 0);

    // Wait states
    apb_xfer(1'b1, 32'h30, 32'hA5A5_0F0F, 4'hF, 3'b000, 3);
    rd(32'h30, 3'b000, 2);
    idle(2);

    // Error cases
    apb_xfer(1'b1, 32'h100, 32'h1234_5678, 4'hF, 3'b000, 0);
    apb_xfer(1'b1, 32'h13, 32'h1234_5678, 4'hF, 3'b000, 1);
    rd(32'h10, 3'b000, 0);
    rd(32'h100, 3'b000, 0);
    rd(32'hFC, 3'b000, 0);
    rd(32'h11, 3'b000, 2);

    // Secure upper half
    apb_xfer(1'b1, 32'h80, 32'hCAFE_F00D, 4'hF, 3'b010, 0);
    rd(32'h80, 3'b000, 0);
    apb_xfer(1'b1, 32'h80, 32'hCAFE_F00D, 4'hF, 3'b000, 0);
    rd(32'h80, 3'b000, 0);
    rd(32'h80, 3'b010, 1);
    apb_xfer(1'b1, 32'h7C, 32'h0BAD_CAFE, 4'hF, 3'b010, 0);
    rd(32'h7C, 3'b010, 0);

    // penable without setup in IDLE is ignored
    @(negedge pclk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0; pstrb = 4'hF;
    @(negedge pclk);
    chk("stray_penable", {31'b0, pready}, 32'd0);
    @(negedge pclk);
    chk("stray_penable2", {31'b0, pready}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    rd(32'h10, 3'b000, 0);

    // Abort by dropping psel, then a normal transfer
    abort_xfer(32'h40, 32'h5555_AAAA, 3);
    rd(32'h40, 3'b000, 0);
    apb_xfer(1'b1, 32'h40, 32'h7777_8888, 4'hF, 3'b000, 1);
    rd(32'h40, 3'b000, 0);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(9, 0);
      if (r < 7)       a = {24'h0, 6'($urandom), 2'b00};
      else if (r == 7) a = {24'h0, 6'($urandom), 2'($urandom_range(3, 1))};
      else if (r == 8) a = 32'h100 + {24'h0, 6'($urandom), 2'b00};
      else             a = ($urandom_range(1, 0) == 1) ? 32'hFC : 32'h100;
      apb_xfer(1'($urandom), a, $urandom, 4'($urandom), 3'($urandom), $urandom_range(3, 0));
      if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 0));
    end

    // Reset during a wait=5 access
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h1357_9BDF;
    pstrb = 4'hF; pprot = 3'b000; cfg_wait_states = 4'd5;
    @(posedge pclk);
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    preset = 1'b1;
    #1;
    chk("midrst_pready", {31'b0, pready}, 32'd0);
    chk("midrst_pslverr", {31'b0, pslverr}, 32'd0);
    chk("midrst_prdata", prdata, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    preset = 1'b0;
    for (int i = 0; i < 64; i++) mem_m[i] = 32'h0;
    for (int i = 0; i < 64; i++) rd(32'(i * 4), 3'b000, 0);
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
